// File: rtl/synth_pkg.sv
//------------------------------------------------------------------------------
// Module   : synth_pkg
// Brief    : Shared constants and types for the synth SPI register bridge.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package synth_pkg;

    localparam int          SPI_FRAME_BITS       = 32;
    localparam logic [7:0]  SPI_STATUS_SIGNATURE = 8'hA5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        HOLD   = 2'd2,
        COMMIT = 2'd3
    } SpiBridgeState_t;

endpackage

`default_nettype wire

// File: rtl/spi_input_synchronizer.sv
//------------------------------------------------------------------------------
// Module   : spi_input_synchronizer
// Brief    : Multi-flop synchroniser with level, rise and fall outputs.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module spi_input_synchronizer #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic i_Clock,
    input  logic i_Reset,
    input  logic i_Async,
    output logic o_Level,
    output logic o_Rise,
    output logic o_Fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic [SYNC_STAGES:0]   valid_q;

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            sync_q  <= {SYNC_STAGES{RESET_VALUE}};
            hist_q  <= RESET_VALUE;
            valid_q <= '0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], i_Async};
            hist_q  <= sync_q[SYNC_STAGES-1];
            valid_q <= {valid_q[SYNC_STAGES-1:0], 1'b1};
        end
    end

    // Edges stay masked until the pipe holds only real pin samples, so a pin
    // differing from its reset value at reset release does not look like an edge.
    assign o_Level = sync_q[SYNC_STAGES-1];
    assign o_Rise  = valid_q[SYNC_STAGES] &  o_Level & ~hist_q;
    assign o_Fall  = valid_q[SYNC_STAGES] & ~o_Level &  hist_q;

endmodule

`default_nettype wire

// File: rtl/spi_register_bridge.sv
//------------------------------------------------------------------------------
// Module   : spi_register_bridge
// Brief    : SPI mode-0 slave turning 32-bit frames into register-write strobes.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module spi_register_bridge
    import synth_pkg::*;
#(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  i_Clock,
    input  logic                  i_Reset,
    input  logic                  i_SpiSclk,
    input  logic                  i_SpiCsN,
    input  logic                  i_SpiMosi,
    output logic                  o_SpiMiso,
    output logic [ADDR_WIDTH-1:0] o_RegisterNumber,
    output logic [DATA_WIDTH-1:0] o_RegisterValue,
    output logic                  o_RegisterWriteEnable,
    output logic                  o_FrameError
);

    localparam logic [5:0] LAST_BIT  = 6'(SPI_FRAME_BITS - 1);
    localparam logic [5:0] FULL_BITS = 6'(SPI_FRAME_BITS);

    logic sclk_level, sclk_rise, sclk_fall;
    logic cs_level, cs_rise, cs_fall;
    logic mosi_level, mosi_rise, mosi_fall;
    logic w_unused;

    spi_input_synchronizer #(.SYNC_STAGES(SYNC_STAGES), .RESET_VALUE(1'b0)) u_sync_sclk (
        .i_Clock(i_Clock), .i_Reset(i_Reset), .i_Async(i_SpiSclk),
        .o_Level(sclk_level), .o_Rise(sclk_rise), .o_Fall(sclk_fall)
    );

    spi_input_synchronizer #(.SYNC_STAGES(SYNC_STAGES), .RESET_VALUE(1'b1)) u_sync_csn (
        .i_Clock(i_Clock), .i_Reset(i_Reset), .i_Async(i_SpiCsN),
        .o_Level(cs_level), .o_Rise(cs_rise), .o_Fall(cs_fall)
    );

    spi_input_synchronizer #(.SYNC_STAGES(SYNC_STAGES), .RESET_VALUE(1'b0)) u_sync_mosi (
        .i_Clock(i_Clock), .i_Reset(i_Reset), .i_Async(i_SpiMosi),
        .o_Level(mosi_level), .o_Rise(mosi_rise), .o_Fall(mosi_fall)
    );

    assign w_unused = ^{sclk_level, cs_level, mosi_rise, mosi_fall};

    SpiBridgeState_t             state_q;
    logic [5:0]                  bit_cnt_q;
    logic                        overrun_q;
    logic [SPI_FRAME_BITS-1:0]   rx_q;
    logic [SPI_FRAME_BITS-1:0]   miso_sr_q;
    logic                        miso_q;
    logic [7:0]                  count_q;
    logic [ADDR_WIDTH-1:0]       number_q;
    logic [DATA_WIDTH-1:0]       value_q;
    logic                        we_q;
    logic                        err_q;

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            overrun_q <= 1'b0;
            rx_q      <= '0;
            miso_sr_q <= '0;
            miso_q    <= 1'b0;
            count_q   <= '0;
            number_q  <= '0;
            value_q   <= '0;
            we_q      <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            we_q  <= 1'b0;
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cs_fall) begin
                        state_q   <= SHIFT;
                        bit_cnt_q <= '0;
                        overrun_q <= 1'b0;
                        miso_sr_q <= {SPI_STATUS_SIGNATURE, count_q, 16'h0000};
                        miso_q    <= SPI_STATUS_SIGNATURE[7];
                    end
                end
                SHIFT, HOLD: begin
                    // Chip-select release wins; any coincident SCLK edge is dropped.
                    if (cs_rise) begin
                        miso_q <= 1'b0;
                        if (bit_cnt_q == FULL_BITS && !overrun_q) begin
                            state_q <= COMMIT;
                        end else begin
                            err_q   <= 1'b1;
                            state_q <= IDLE;
                        end
                    end else begin
                        if (sclk_rise) begin
                            if (state_q == SHIFT) begin
                                rx_q      <= {rx_q[SPI_FRAME_BITS-2:0], mosi_level};
                                bit_cnt_q <= bit_cnt_q + 6'd1;
                                if (bit_cnt_q == LAST_BIT) begin
                                    state_q <= HOLD;
                                end
                            end else begin
                                overrun_q <= 1'b1;
                            end
                        end
                        if (sclk_fall) begin
                            miso_sr_q <= {miso_sr_q[SPI_FRAME_BITS-2:0], 1'b0};
                            miso_q    <= miso_sr_q[SPI_FRAME_BITS-2];
                        end
                    end
                end
                COMMIT: begin
                    number_q <= rx_q[SPI_FRAME_BITS-1 -: ADDR_WIDTH];
                    value_q  <= rx_q[DATA_WIDTH-1:0];
                    we_q     <= 1'b1;
                    count_q  <= count_q + 8'd1;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_SpiMiso             = miso_q;
    assign o_RegisterNumber      = number_q;
    assign o_RegisterValue       = value_q;
    assign o_RegisterWriteEnable = we_q;
    assign o_FrameError          = err_q;

endmodule

`default_nettype wire
